// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the data cache controller.
// FSM state enum, funct3 size codes, store lane merge.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_MISS,
    S_WR_THRU
  } dcache_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic store_ok(
    input logic [2:0] f3
  );
    return (f3 == F3_B) || (f3 == F3_H) ||
           (f3 == F3_W) || (f3 == F3_BU) ||
           (f3 == F3_HU);
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = old;
    case (f3)
      F3_B, F3_BU: r[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H, F3_HU: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      F3_W:        r = wdata;
      default:     r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/data storage for one-word lines.
// Async read, sync byte-enabled write, async valid clear.
module dcache_array #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 26,
  parameter int SETS_LOG2  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SETS_LOG2-1:0]    i_rd_idx,
  output logic                    o_rd_valid,
  output logic [TAG_W-1:0]        o_rd_tag,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  input  logic                    i_wr_en,
  input  logic                    i_tag_we,
  input  logic [SETS_LOG2-1:0]    i_wr_idx,
  input  logic [TAG_W-1:0]        i_wr_tag,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  input  logic [DATA_WIDTH-1:0]   i_wr_data
);

  localparam int SETS = 1 << SETS_LOG2;

  logic [SETS-1:0]       r_valid;
  logic [TAG_W-1:0]      r_tag  [SETS];
  logic [DATA_WIDTH-1:0] r_data [SETS];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

  // Valid bits: cleared by reset, set by a line fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage; data written per byte lane.
  always_ff @(posedge clk) begin
    if (i_tag_we) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
    if (i_wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_wr_be[b]) begin
          r_data[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-allocate D$.
// Optional hit/miss counters under DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_funct3,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  localparam int TAG_W = ADDR_WIDTH - SETS_LOG2 - 2;

  dcache_state_t r_state;
  logic [SETS_LOG2-1:0] r_idx;
  logic [TAG_W-1:0]     r_tag;
  logic [1:0]           r_off;

  logic [SETS_LOG2-1:0]    w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic [SETS_LOG2-1:0]    w_rd_idx;
  logic [TAG_W-1:0]        w_cmp_tag;
  logic                    w_rd_valid;
  logic [TAG_W-1:0]        w_rd_tag;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic                    w_tag_eq;
  logic                    w_hit;
  logic                    w_idle;
  logic                    w_fill;
  logic                    w_st_wr;
  logic [DATA_WIDTH/8-1:0] w_wr_be;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic                    w_ld_hit;
  logic                    w_ld_miss;
  logic                    w_st_go;

  assign w_idx  = cpu_addr[SETS_LOG2+1:2];
  assign w_tag  = cpu_addr[ADDR_WIDTH-1:SETS_LOG2+2];
  assign w_idle = (r_state == S_IDLE);

  // Look up with the CPU address when idle, the latched one otherwise.
  assign w_rd_idx  = w_idle ? w_idx : r_idx;
  assign w_cmp_tag = w_idle ? w_tag : r_tag;
  assign w_tag_eq  = w_rd_valid & (w_rd_tag == w_cmp_tag);
  assign w_hit     = cpu_req & w_tag_eq;

  assign w_ld_hit  = w_idle & cpu_req & ~cpu_we & w_hit;
  assign w_ld_miss = w_idle & cpu_req & ~cpu_we & ~w_hit;
  assign w_st_go   = w_idle & cpu_req & cpu_we &
                     store_ok(cpu_funct3);

  assign w_fill  = (r_state == S_RD_MISS) & mem_ack;
  assign w_st_wr = (r_state == S_WR_THRU) & mem_ack & w_tag_eq;

  assign w_wr_data = w_fill ? mem_rdata :
    byte_merge(w_rd_data, mem_wdata, mem_funct3, r_off);
  assign w_wr_be = w_fill ? '1 : byte_en(mem_funct3, r_off);

  assign cpu_hit   = w_hit;
  assign cpu_rdata = w_hit ? w_rd_data : '0;
  assign cpu_stall = rst_n & cpu_req
    & ~w_ld_hit
    & ~(~w_idle & mem_ack & cpu_we)
    & ~(cpu_we & ~store_ok(cpu_funct3));

  dcache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_W      (TAG_W),
    .SETS_LOG2  (SETS_LOG2)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_rd_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill | w_st_wr),
    .i_tag_we   (w_fill),
    .i_wr_idx   (r_idx),
    .i_wr_tag   (r_tag),
    .i_wr_be    (w_wr_be),
    .i_wr_data  (w_wr_data)
  );

  // Miss/store sequencer with registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tag      <= '0;
      r_off      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= 3'b000;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ld_miss || w_st_go) begin
            r_state    <= w_ld_miss ? S_RD_MISS : S_WR_THRU;
            r_idx      <= w_idx;
            r_tag      <= w_tag;
            r_off      <= cpu_addr[1:0];
            mem_req    <= 1'b1;
            mem_we     <= w_st_go;
            mem_addr   <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_funct3 <= cpu_funct3;
            if (w_st_go) mem_wdata <= cpu_wdata;
          end
        end
        S_RD_MISS, S_WR_THRU: begin
          if (mem_ack) begin
            r_state <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating load hit/miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (w_ld_hit && stat_hits != '1)
        stat_hits <= stat_hits + 32'd1;
      if (w_ld_miss && stat_misses != '1)
        stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl.
// Memory latency is modelled inside the access task.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int errs;
  int checks;

  dcache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_funct3 (cpu_funct3),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .cpu_hit    (cpu_hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One CPU access; memory acks in the (lat+1)th cycle of mem_req.
  task automatic access(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  int          lat,
    input  logic [31:0] fill,
    output int          stall,
    output int          nreq,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        mwe,
    output logic [31:0] maddr,
    output logic [31:0] mwd,
    output logic [2:0]  mf3
  );
    bit done;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_funct3 = f3;
    cpu_addr = addr;
    cpu_wdata = wd;
    mem_rdata = fill;
    stall = 0;
    nreq = 0;
    rdata = '0;
    hit = 1'b0;
    mwe = 1'b0;
    maddr = '0;
    mwd = '0;
    mf3 = '0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (mem_req) begin
        if (nreq == 0) begin
          mwe = mem_we;
          maddr = mem_addr;
          mwd = mem_wdata;
          mf3 = mem_funct3;
        end
        nreq++;
      end
      mem_ack = mem_req && (nreq == lat + 1);
      #1;
      if (!cpu_stall) begin
        done = 1;
        rdata = cpu_rdata;
        hit = cpu_hit;
      end else begin
        stall++;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL access_timeout addr=%h got stall=%0d", addr, stall);
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_funct3 = 3'b010;
    cpu_addr = 32'h40;
    cpu_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, cpu_hit, cpu_stall} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_ctl got %b exp 0000",
        {mem_req, mem_we, cpu_hit, cpu_stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, mem_funct3} !== '0) begin
      errs++;
      $display("FAIL reset_data got %h %h %h %b exp 0",
        mem_addr, mem_wdata, cpu_rdata, mem_funct3);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_miss_hit();
    int st, nr;
    logic [31:0] rd, ma, mw;
    logic h, we;
    logic [2:0] f3;
    access(0, 3'b010, 32'h40, 0, 3, 32'hDEADBEEF,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if (st !== 5) begin
      errs++;
      $display("FAIL miss_stall got %0d exp 5", st);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL miss_rdata got %h exp deadbeef", rd);
    end
    checks++;
    if ({nr, we, ma} !== {32'd4, 1'b0, 32'h40}) begin
      errs++;
      $display("FAIL miss_memreq got n=%0d we=%b a=%h exp 4 0 40",
        nr, we, ma);
    end
    access(0, 3'b010, 32'h40, 0, 3, 32'h0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, nr, h} !== {32'd0, 32'd0, 1'b1}) begin
      errs++;
      $display("FAIL hit got st=%0d n=%0d hit=%b exp 0 0 1",
        st, nr, h);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL hit_rdata got %h exp deadbeef", rd);
    end
  endtask

  task automatic test_store_merge();
    int st, nr;
    logic [31:0] rd, ma, mw;
    logic h, we;
    logic [2:0] f3;
    access(1, 3'b000, 32'h42, 32'hAB, 2, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if (st !== 3) begin
      errs++;
      $display("FAIL sb_stall got %0d exp 3", st);
    end
    checks++;
    if ({we, f3, ma, mw} !== {1'b1, 3'b000, 32'h40, 32'hAB}) begin
      errs++;
      $display("FAIL sb_mem got we=%b f3=%b a=%h d=%h exp 1 000 40 ab",
        we, f3, ma, mw);
    end
    access(0, 3'b010, 32'h40, 0, 2, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, nr, rd} !== {32'd0, 32'd0, 32'hDEABBEEF}) begin
      errs++;
      $display("FAIL sb_merge got st=%0d n=%0d d=%h exp 0 0 deabbeef",
        st, nr, rd);
    end
    access(1, 3'b001, 32'h42, 32'hCAFE, 1, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if (st !== 2) begin
      errs++;
      $display("FAIL sh_stall got %0d exp 2", st);
    end
    access(0, 3'b010, 32'h40, 0, 1, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, rd} !== {32'd0, 32'hCAFEBEEF}) begin
      errs++;
      $display("FAIL sh_merge got st=%0d d=%h exp 0 cafebeef", st, rd);
    end
  endtask

  task automatic test_unsupported();
    int st, nr;
    logic [31:0] rd, ma, mw;
    logic h, we;
    logic [2:0] f3;
    access(1, 3'b011, 32'h40, 32'hFFFFFFFF, 1, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, nr} !== {32'd0, 32'd0}) begin
      errs++;
      $display("FAIL bad_f3 got st=%0d n=%0d exp 0 0", st, nr);
    end
    access(0, 3'b010, 32'h40, 0, 1, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, rd} !== {32'd0, 32'hCAFEBEEF}) begin
      errs++;
      $display("FAIL bad_f3_data got st=%0d d=%h exp 0 cafebeef",
        st, rd);
    end
  endtask

  task automatic test_store_no_alloc();
    int st, nr;
    logic [31:0] rd, ma, mw;
    logic h, we;
    logic [2:0] f3;
    access(1, 3'b010, 32'h80, 32'h12345678, 2, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, ma, mw} !== {32'd3, 32'h80, 32'h12345678}) begin
      errs++;
      $display("FAIL sw_miss got st=%0d a=%h d=%h exp 3 80 12345678",
        st, ma, mw);
    end
    access(0, 3'b010, 32'h80, 0, 2, 32'h12345678,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, rd} !== {32'd4, 32'h12345678}) begin
      errs++;
      $display("FAIL no_alloc got st=%0d d=%h exp 4 12345678", st, rd);
    end
  endtask

  task automatic test_evict();
    int st, nr;
    logic [31:0] rd, ma, mw;
    logic h, we;
    logic [2:0] f3;
    access(0, 3'b010, 32'h40, 0, 1, 32'hDEADBEEF,
      st, nr, rd, h, we, ma, mw, f3);
    access(0, 3'b010, 32'h440, 0, 1, 32'h44044044,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, rd, ma} !== {32'd3, 32'h44044044, 32'h440}) begin
      errs++;
      $display("FAIL evict_fill got st=%0d d=%h a=%h exp 3 44044044 440",
        st, rd, ma);
    end
    access(0, 3'b010, 32'h40, 0, 1, 32'hDEADBEEF,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, rd} !== {32'd3, 32'hDEADBEEF}) begin
      errs++;
      $display("FAIL evict_remiss got st=%0d d=%h exp 3 deadbeef",
        st, rd);
    end
  endtask

  task automatic test_back_to_back();
    int st, nr;
    logic [31:0] rd, ma, mw;
    logic h, we;
    logic [2:0] f3;
    access(0, 3'b010, 32'h44, 0, 0, 32'h11111111,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, nr} !== {32'd2, 32'd1}) begin
      errs++;
      $display("FAIL lat0_miss got st=%0d n=%0d exp 2 1", st, nr);
    end
    access(0, 3'b010, 32'h48, 0, 2, 32'h22222222,
      st, nr, rd, h, we, ma, mw, f3);
    access(0, 3'b010, 32'h44, 0, 2, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, rd} !== {32'd0, 32'h11111111}) begin
      errs++;
      $display("FAIL b2b_hit0 got st=%0d d=%h exp 0 11111111", st, rd);
    end
    access(0, 3'b010, 32'h48, 0, 2, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, rd} !== {32'd0, 32'h22222222}) begin
      errs++;
      $display("FAIL b2b_hit1 got st=%0d d=%h exp 0 22222222", st, rd);
    end
  endtask

  task automatic test_reset_mid_miss();
    int st, nr;
    logic [31:0] rd, ma, mw;
    logic h, we;
    logic [2:0] f3;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_funct3 = 3'b010;
    cpu_addr = 32'hC0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errs++;
      $display("FAIL mid_req_up got %b exp 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, cpu_stall} !== 2'b00) begin
      errs++;
      $display("FAIL mid_reset got req=%b stall=%b exp 0 0",
        mem_req, cpu_stall);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 3'b010, 32'hC0, 0, 3, 32'h0C0C0C0C,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({st, rd} !== {32'd5, 32'h0C0C0C0C}) begin
      errs++;
      $display("FAIL post_reset_miss got st=%0d d=%h exp 5 0c0c0c0c",
        st, rd);
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    int st, nr;
    logic [31:0] rd, ma, mw;
    logic h, we;
    logic [2:0] f3;
    do_reset();
    access(0, 3'b010, 32'h40, 0, 1, 32'h1,
      st, nr, rd, h, we, ma, mw, f3);
    access(0, 3'b010, 32'h44, 0, 1, 32'h2,
      st, nr, rd, h, we, ma, mw, f3);
    access(0, 3'b010, 32'h44, 0, 1, 0,
      st, nr, rd, h, we, ma, mw, f3);
    checks++;
    if ({stat_hits, stat_misses} !== {32'd3, 32'd2}) begin
      errs++;
      $display("FAIL stats got h=%0d m=%0d exp 3 2",
        stat_hits, stat_misses);
    end
  endtask
`endif

  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_load_miss_hit();
    test_store_merge();
    test_unsupported();
    test_store_no_alloc();
    test_evict();
    test_back_to_back();
    test_reset_mid_miss();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
